// File: rtl/seg_stream_rx.sv
// seg_stream_rx: recovers symbols from a time-multiplexed 7-segment bus and groups them into gap-delimited frames.
// Define ECLIPSE_MATCH_EN to build the "ECLIPSe" word comparator behind word_match; otherwise word_match is tied low.
//
// state   | meaning
// IDLE    | no frame open, waiting for the first symbol
// COLLECT | frame open, buffering symbols and timing the blank gap
// DONE    | frame just published; a symbol seen here opens the next frame
module seg_stream_rx #(
  parameter int GAP_CYCLES = 64,
  parameter int MAX_SYMS   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            seg_in,
  output logic                  sym_valid,
  output logic [4:0]            sym_code,
  output logic                  sym_err,
  output logic                  frame_valid,
  output logic [4:0]            frame_len,
  output logic [5*MAX_SYMS-1:0] frame_data,
  output logic                  frame_ovf,
  output logic                  frame_err,
  output logic                  word_match
);

  localparam int ZW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [6:0]            r_seg_q, r_seg_qq;
  logic [ZW-1:0]         r_zero_cnt;
  logic [4:0]            r_len;
  logic [5*MAX_SYMS-1:0] r_buf;
  logic                  r_ovf, r_err;
  logic                  r_sym_valid, r_sym_err;
  logic [4:0]            r_sym_code;
  logic                  r_frame_valid, r_frame_ovf, r_frame_err;
  logic [4:0]            r_frame_len;
  logic [5*MAX_SYMS-1:0] r_frame_data;
  logic                  w_event, w_bad, w_gap_hit;
  logic [4:0]            w_code;

  function automatic logic [5:0] decode(input logic [6:0] p);
    logic [5:0] r;
    case (p)
      7'b0111111: r = {1'b0, 5'h00};
      7'b0000110: r = {1'b0, 5'h01};
      7'b1011011: r = {1'b0, 5'h02};
      7'b1001111: r = {1'b0, 5'h03};
      7'b1100110: r = {1'b0, 5'h04};
      7'b1101101: r = {1'b0, 5'h05};
      7'b1111101: r = {1'b0, 5'h06};
      7'b0000111: r = {1'b0, 5'h07};
      7'b1111111: r = {1'b0, 5'h08};
      7'b1101111: r = {1'b0, 5'h09};
      7'b1110111: r = {1'b0, 5'h0A};
      7'b1111100: r = {1'b0, 5'h0B};
      7'b0111001: r = {1'b0, 5'h0C};
      7'b1011110: r = {1'b0, 5'h0D};
      7'b1111001: r = {1'b0, 5'h0E};
      7'b1110001: r = {1'b0, 5'h0F};
      7'b0111000: r = {1'b0, 5'h10};
      7'b0110000: r = {1'b0, 5'h11};
      7'b1110011: r = {1'b0, 5'h12};
      7'b1111011: r = {1'b0, 5'h13};
      default:    r = {1'b1, 5'h1F};
    endcase
    return r;
  endfunction

  assign {w_bad, w_code} = decode(r_seg_q);
  assign w_event   = (r_seg_q != 7'd0) && (r_seg_q != r_seg_qq);
  // The gap-closing blank is the GAP_CYCLES-th one, so fire while the count still reads one less.
  assign w_gap_hit = (r_state == COLLECT) && (r_seg_q == 7'd0) &&
                     (r_zero_cnt == ZW'(GAP_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_event) w_state_nxt = COLLECT;
      COLLECT: if (w_gap_hit) w_state_nxt = DONE;
      DONE:    w_state_nxt = w_event ? COLLECT : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg_q       <= '0;
      r_seg_qq      <= '0;
      r_zero_cnt    <= '0;
      r_len         <= '0;
      r_buf         <= '0;
      r_ovf         <= 1'b0;
      r_err         <= 1'b0;
      r_sym_valid   <= 1'b0;
      r_sym_code    <= '0;
      r_sym_err     <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_len   <= '0;
      r_frame_data  <= '0;
      r_frame_ovf   <= 1'b0;
      r_frame_err   <= 1'b0;
    end else begin
      r_seg_q       <= seg_in;
      r_seg_qq      <= r_seg_q;
      r_sym_valid   <= w_event;
      r_frame_valid <= 1'b0;
      if (w_event) begin
        r_sym_code <= w_code;
        r_sym_err  <= w_bad;
      end
      if (w_event && (r_state != COLLECT)) begin
        r_buf      <= (5*MAX_SYMS)'(w_code);
        r_len      <= 5'd1;
        r_ovf      <= 1'b0;
        r_err      <= w_bad;
        r_zero_cnt <= '0;
      end else if (r_state == COLLECT) begin
        if (w_event) begin
          for (int i = 0; i < MAX_SYMS; i++)
            if (i == int'(r_len)) r_buf[5*i +: 5] <= w_code;
          if (int'(r_len) >= MAX_SYMS) r_ovf <= 1'b1;
          else                         r_len <= r_len + 5'd1;
          r_err      <= r_err | w_bad;
          r_zero_cnt <= '0;
        end else if (w_gap_hit) begin
          r_frame_valid <= 1'b1;
          r_frame_len   <= r_len;
          r_frame_data  <= r_buf;
          r_frame_ovf   <= r_ovf;
          r_frame_err   <= r_err;
          r_buf         <= '0;
          r_len         <= '0;
          r_ovf         <= 1'b0;
          r_err         <= 1'b0;
          r_zero_cnt    <= '0;
        end else if ((r_seg_q == 7'd0) && (int'(r_zero_cnt) < GAP_CYCLES)) begin
          r_zero_cnt <= r_zero_cnt + ZW'(1);
        end
      end
    end
  end

  assign sym_valid   = r_sym_valid;
  assign sym_code    = r_sym_code;
  assign sym_err     = r_sym_err;
  assign frame_valid = r_frame_valid;
  assign frame_len   = r_frame_len;
  assign frame_data  = r_frame_data;
  assign frame_ovf   = r_frame_ovf;
  assign frame_err   = r_frame_err;

`ifdef ECLIPSE_MATCH_EN
  localparam logic [34:0] WORD = {5'h13, 5'h05, 5'h12, 5'h11, 5'h10, 5'h0C, 5'h0E};
  logic w_match;
  logic r_word_match;

  if (MAX_SYMS >= 7) begin : g_cmp
    assign w_match = (r_len == 5'd7) && !r_ovf && (r_buf[34:0] == WORD);
  end else begin : g_no_cmp
    assign w_match = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_word_match <= 1'b0;
    else if (w_gap_hit) r_word_match <= w_match;
  end

  assign word_match = r_word_match;
`else
  assign word_match = 1'b0;
`endif

endmodule
